// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer running on the TX baud clock.
// Sends one frame per request: start bit, DATA_WIDTH data bits LSB first,
// an optional even/odd parity bit, then a stop bit. TX_OUT and Busy are
// registered and are driven from the next-state values, so the line changes
// on the same edge that the state does.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // A single-bit frame still needs a one-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic                    par_bit;

  assign cnt_inc = cnt_q + 1'b1;
  // Even parity is the XOR of the data; odd parity is its complement.
  assign par_bit = (^data_q) ^ par_typ_q;

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // State, counter, latched request and registered outputs; reset wins over a request.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, and the line value/busy flag that the next state presents.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end

      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last data bit is on the line; the counter is parked instead of wrapping.
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          tx_d  = data_q[cnt_inc];
        end
      end

      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      STOP: begin
        // Back to IDLE with the line high; a new request is sampled there.
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of the UART transmit framer.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at that same point, well away from the next active edge.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected line sequences, first bit in the MSB position.
  logic [10:0] seq_a5_even;
  logic [10:0] seq_a5_odd;
  logic [10:0] seq_07_even;
  logic [10:0] seq_ff_nopar;
  logic [10:0] seq_55_even;
  logic [10:0] seq_aa_even;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle that must show an idle line.
  task automatic idle_check(input string tag);
    tick();
    check({tag, "_tx"}, TX_OUT, 1'b1);
    check({tag, "_busy"}, Busy, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
  endtask

  // Walks one frame of len bits starting at the edge that accepts the request.
  // After the first bit, Data_Valid becomes keep_dv and P_DATA next_data.
  // When poke_at >= 0 a competing request with new data and flipped parity
  // type is pulsed at that bit position.
  task automatic check_frame(input string tag, input logic [10:0] seq, input int len,
                             input logic keep_dv, input logic [7:0] next_data,
                             input int poke_at);
    for (int i = 0; i < len; i++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, i), TX_OUT, seq[len-1-i]);
      check($sformatf("%s_busy%0d", tag, i), Busy, 1'b1);
      if (i == 0) begin
        Data_Valid = keep_dv;
        P_DATA     = next_data;
      end
      if (poke_at >= 0 && i == poke_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'h3C;
        PAR_TYP    = ~PAR_TYP;
      end
      if (poke_at >= 0 && i == poke_at + 1) Data_Valid = 1'b0;
    end
  endtask

  initial begin
    seq_a5_even  = 11'b01010010101;
    seq_a5_odd   = 11'b01010010111;
    seq_07_even  = 11'b01110000011;
    seq_ff_nopar = 11'b00111111111;  // 10-bit frame in the low bits
    seq_55_even  = 11'b01010101001;
    seq_aa_even  = 11'b00101010101;

    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset state.
    tick();
    tick();
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);
    RST = 1'b0;
    idle_check("post_reset");

    // Even parity, 0xA5.
    send(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", seq_a5_even, 11, 1'b0, 8'hA5, -1);
    idle_check("a5_even_end");

    // Odd parity, 0xA5.
    send(8'hA5, 1'b1, 1'b1);
    check_frame("a5_odd", seq_a5_odd, 11, 1'b0, 8'hA5, -1);
    idle_check("a5_odd_end");

    // Even parity, 0x07: odd number of ones gives parity bit 1.
    send(8'h07, 1'b1, 1'b0);
    check_frame("07_even", seq_07_even, 11, 1'b0, 8'h07, -1);
    idle_check("07_even_end");

    // No parity, 0xFF: 10-bit frame.
    send(8'hFF, 1'b0, 1'b0);
    check_frame("ff_nopar", seq_ff_nopar, 10, 1'b0, 8'hFF, -1);
    idle_check("ff_nopar_end");

    // Mid-frame request with new data and flipped parity type is ignored.
    send(8'hA5, 1'b1, 1'b0);
    check_frame("ignore", seq_a5_even, 11, 1'b0, 8'hA5, 3);
    idle_check("ignore_end0");
    idle_check("ignore_end1");
    idle_check("ignore_end2");

    // Reset during the 4th data bit aborts the frame.
    PAR_TYP = 1'b0;
    send(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort_bit%0d", i), TX_OUT, seq_a5_even[10-i]);
      check($sformatf("abort_busy%0d", i), Busy, 1'b1);
      if (i == 0) Data_Valid = 1'b0;
    end
    RST = 1'b1;
    tick();
    check("abort_rst_tx", TX_OUT, 1'b1);
    check("abort_rst_busy", Busy, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) idle_check($sformatf("abort_idle%0d", i));

    // Reset and request together: reset wins and the request is dropped.
    RST = 1'b1;
    send(8'h00, 1'b1, 1'b0);
    tick();
    check("rst_dv_tx", TX_OUT, 1'b1);
    check("rst_dv_busy", Busy, 1'b0);
    RST        = 1'b0;
    Data_Valid = 1'b0;
    idle_check("rst_dv_after0");
    idle_check("rst_dv_after1");

    // Back-to-back with Data_Valid held: one idle-high cycle between frames.
    send(8'h55, 1'b1, 1'b0);
    check_frame("b2b_55", seq_55_even, 11, 1'b1, 8'hAA, -1);
    idle_check("b2b_gap");
    check_frame("b2b_aa", seq_aa_even, 11, 1'b0, 8'hAA, -1);
    idle_check("b2b_end0");
    idle_check("b2b_end1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
